sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
- Shares one synchronous single-port SRAM between two requesters: instruction fetch (read-only) and load/store data access.
- Sits between the pipeline stages and the unified SRAM. The fetch stage drives the inst port; the execute/memory stages drive the data port.
- Uses a req/addr_ok/data_ok handshake with at most one access per cycle, pipelined so back-to-back accesses run at full throughput.
- Data has priority over inst, bounded by an anti-starvation counter.

Parameters:
- STARVE_MAX, 4, number of consecutive data grants while inst_req is held that forces the next grant to inst (range 1..15).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- inst_req  input  1  fetch request valid.
- inst_addr  input  32  fetch byte address.
- inst_addr_ok  output  1  inst request accepted this cycle.
- inst_data_ok  output  1  inst read data valid this cycle.
- inst_rdata  output  32  inst read data.
- data_req  input  1  data request valid.
- data_wr  input  1  1 = store, 0 = load.
- data_wstrb  input  4  byte enables for a store.
- data_addr  input  32  data byte address.
- data_wdata  input  32  store data.
- data_addr_ok  output  1  data request accepted this cycle.
- data_data_ok  output  1  data response (load data or store completion) this cycle.
- data_rdata  output  32  load data.
- sram_en  output  1  SRAM enable.
- sram_we  output  4  SRAM byte write enables.
- sram_addr  output  32  SRAM address.
- sram_wdata  output  32  SRAM write data.
- sram_rdata  input  32  SRAM read data, valid one cycle after the enable.

Behaviour:
- Grant logic is combinational each cycle.
  - grant_data = data_req & ~(inst_req & starve_cnt == STARVE_MAX).
  - grant_inst = inst_req & ~grant_data.
  - At most one grant per cycle.
- inst_addr_ok = grant_inst; data_addr_ok = grant_data. A request is accepted exactly in a cycle where req & addr_ok.
- SRAM drive:
  - sram_en = grant_inst | grant_data.
  - sram_addr is data_addr when grant_data, else inst_addr.
  - sram_we = data_wstrb when (grant_data & data_wr), else 4'b0.
  - sram_wdata = data_wdata.
  - When nothing is granted: sram_en=0, sram_we=0, sram_addr=0.
- Response pipeline registers: resp_valid, resp_owner (0=inst, 1=data), loaded every cycle from sram_en and grant_data.
  - inst_data_ok = resp_valid & ~resp_owner.
  - data_data_ok = resp_valid & resp_owner.
  - inst_rdata = data_rdata = sram_rdata (passthrough; meaningful only with the matching data_ok).
- Latency: data_ok is asserted exactly 1 cycle after the addr_ok handshake. Every accepted request receives exactly one data_ok, including stores.
- Throughput: a new grant is allowed in the same cycle as a data_ok. Sustained rate is 1 access per cycle.
- Order: responses return in grant order. No reordering, no buffering beyond one stage.
- Starvation counter starve_cnt, 4 bits:
  - grant_data & inst_req: increment, saturating at STARVE_MAX.
  - grant_inst: clear to 0.
  - ~inst_req: clear to 0.
  - otherwise: hold.
- Simultaneous requests:
  - data wins unless starve_cnt == STARVE_MAX, in which case inst wins.
  - The loser is not accepted; the requester holds req and address stable until its addr_ok.
- Requester rule: requesters do not drop req while addr_ok is low. The arbiter does not check this; if violated, the behaviour is simply "no grant that cycle".
- Reset, asynchronous, active-high:
  - resp_valid=0, resp_owner=0, starve_cnt=0.
  - All combinationally derived outputs (addr_ok, sram_en, sram_we, sram_addr) are forced to 0 while reset is high.
  - data_ok outputs = 0; rdata outputs follow sram_rdata (don't care).
- Reset mid-operation: an in-flight response is dropped and no data_ok follows. Requesters treat reset as cancelling all outstanding accesses.
- No other state; there is no explicit FSM beyond the response stage and the counter.

Test Plan:
1. Reset asserted with inst_req=1, inst_addr=0x1c000000 -> inst_addr_ok=0, sram_en=0. Release reset -> same cycle inst_addr_ok=1, sram_addr=0x1c000000; next cycle inst_data_ok=1, inst_rdata=SRAM word.
2. Store data_req=1, data_wr=1, data_wstrb=4'b0011, data_addr=0x100, data_wdata=0xdeadbeef -> sram_we=4'b0011, sram_addr=0x100; next cycle data_data_ok=1, inst_data_ok=0. A following load from 0x100 returns 0x????beef, upper half unchanged.
3. inst_req and data_req both held high for 12 cycles, STARVE_MAX=4 -> grant pattern D,D,D,D,I repeating. Every data_ok lands 1 cycle after its grant, and the owner matches.
4. Back-to-back inst loads at 0x0, 0x4, 0x8 on consecutive cycles -> inst_addr_ok on 3 consecutive cycles, inst_data_ok on the 3 following cycles, data in order.
5. Reset pulsed the cycle after a data load grant -> no data_data_ok after reset release, starve_cnt=0, first post-reset simultaneous request grants data.
6. inst_req dropped after 2 data grants (starve_cnt=2), then reasserted together with data_req -> counter restarted from 0, so 4 data grants precede the inst grant.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// Purpose: shares one single-port synchronous SRAM between instruction fetch and load/store access.
// Latency: combinational grant and SRAM drive; data_ok exactly one cycle after the addr_ok handshake.
// Backpressure: the losing requester sees addr_ok low and holds req/address until it is granted.
module sram_port_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        sram_en,
  output logic [3:0]  sram_we,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic       grant_inst;
  logic       grant_data;
  logic       starve_hit;

  logic       resp_valid_q, resp_valid_d;
  logic       resp_owner_q, resp_owner_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;

  // Arbitration: data wins unless inst has been passed over STARVE_MAX times in a row.
  always_comb begin
    grant_inst = 1'b0;
    grant_data = 1'b0;
    starve_hit = 1'b0;
    if (!reset) begin
      starve_hit = inst_req && (starve_cnt_q == STARVE_LIM);
      grant_data = data_req && !starve_hit;
      grant_inst = inst_req && !grant_data;
    end
  end

  assign inst_addr_ok = grant_inst;
  assign data_addr_ok = grant_data;

  // SRAM drive follows the winner; idle cycles present a quiet all-zero command.
  always_comb begin
    sram_en   = grant_inst | grant_data;
    sram_we   = 4'b0000;
    sram_addr = 32'h0;
    if (grant_data) begin
      sram_addr = data_addr;
      if (data_wr) begin
        sram_we = data_wstrb;
      end
    end else if (grant_inst) begin
      sram_addr = inst_addr;
    end
  end

  assign sram_wdata = data_wdata;

  // Next state for the response stage and the anti-starvation counter.
  always_comb begin
    resp_valid_d = sram_en;
    resp_owner_d = grant_data;
    starve_cnt_d = starve_cnt_q;
    if (!inst_req || grant_inst) begin
      starve_cnt_d = 4'd0;
    end else if (grant_data && (starve_cnt_q != STARVE_LIM)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  // State registers; reset drops any in-flight response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_valid_q <= 1'b0;
      resp_owner_q <= 1'b0;
      starve_cnt_q <= 4'd0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_owner_q <= resp_owner_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign inst_data_ok = resp_valid_q & ~resp_owner_q;
  assign data_data_ok = resp_valid_q &  resp_owner_q;
  assign inst_rdata   = sram_rdata;
  assign data_rdata   = sram_rdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Purpose: directed bench for sram_port_arbiter with a behavioural SRAM and a response scoreboard.
// Latency: grants checked in the issue cycle; responses checked one cycle later by the monitor.
// Backpressure: stimulus supplies the expected winner each cycle; losers simply re-present.
module tb_sram_port_arbiter;

  logic        clk;
  logic        reset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  sram_port_arbiter #(.STARVE_MAX(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_wstrb   (data_wstrb),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .sram_en      (sram_en),
    .sram_we      (sram_we),
    .sram_addr    (sram_addr),
    .sram_wdata   (sram_wdata),
    .sram_rdata   (sram_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural SRAM: untouched words read as (byte address ^ 32'h5a5a0000).
  logic [31:0] mem [bit [29:0]];

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    if (mem.exists(a[31:2])) return mem[a[31:2]];
    return {a[31:2], 2'b00} ^ 32'h5a5a0000;
  endfunction

  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we != 4'b0000) begin
        logic [31:0] w;
        w = rd_word(sram_addr);
        for (int b = 0; b < 4; b++) begin
          if (sram_we[b]) w[b*8 +: 8] = sram_wdata[b*8 +: 8];
        end
        mem[sram_addr[31:2]] = w;
        sram_rdata <= 32'h0;
      end else begin
        sram_rdata <= rd_word(sram_addr);
      end
    end
  end

  int cyc;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        owner;
    logic [31:0] dat;
    logic        chk;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks;
  int   n_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: every response must match the oldest outstanding grant.
  always @(negedge clk) begin
    if (inst_data_ok || data_data_ok) begin
      if (sb.size() == 0) begin
        check("unexpected_data_ok", {inst_data_ok, data_data_ok}, 2'b00);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("resp_owner", {inst_data_ok, data_data_ok}, e.owner ? 2'b01 : 2'b10);
        check("resp_latency", cyc, e.cyc + 1);
        if (e.chk) begin
          check("resp_rdata", e.owner ? data_rdata : inst_rdata, e.dat);
        end
      end
    end
  end

  // One cycle of stimulus; eg is the expected winner (0 none, 1 inst, 2 data).
  task automatic drive(input logic rst, input logic ireq, input logic [31:0] iaddr,
                       input logic dreq, input logic dwr, input logic [3:0] strb,
                       input logic [31:0] daddr, input logic [31:0] wdata,
                       input int eg, input logic [31:0] iexp, input logic [31:0] dexp);
    exp_t e;
    @(posedge clk);
    #1;
    reset      = rst;
    inst_req   = ireq;
    inst_addr  = iaddr;
    data_req   = dreq;
    data_wr    = dwr;
    data_wstrb = strb;
    data_addr  = daddr;
    data_wdata = wdata;
    if (rst) sb.delete();
    #3;
    check("inst_addr_ok", inst_addr_ok, eg == 1);
    check("data_addr_ok", data_addr_ok, eg == 2);
    check("sram_en", sram_en, eg != 0);
    check("sram_addr", sram_addr, (eg == 2) ? daddr : (eg == 1) ? iaddr : 32'h0);
    check("sram_we", sram_we, (eg == 2 && dwr) ? strb : 4'b0000);
    if (rst) check("data_ok_in_reset", {inst_data_ok, data_data_ok}, 2'b00);
    if (eg == 1) begin
      e.owner = 1'b0; e.dat = iexp; e.chk = 1'b1; e.cyc = cyc;
      sb.push_back(e);
    end else if (eg == 2) begin
      e.owner = 1'b1; e.dat = dexp; e.chk = !dwr; e.cyc = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 32'h0);
  endtask

  // Both requesters held: inst at 0x300, data load at 0x200.
  task automatic both(input logic rst, input int eg);
    drive(rst, 1'b1, 32'h300, 1'b1, 1'b0, 4'h0, 32'h200, 32'h0, eg, 32'h5a5a0300, 32'h5a5a0200);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pat3[12];
    int pat6[5];
    pat3 = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1, 2, 2};
    pat6 = '{2, 2, 2, 2, 1};
    n_checks   = 0;
    n_err      = 0;
    cyc        = 0;
    reset      = 1'b1;
    inst_req   = 1'b1;
    inst_addr  = 32'h1c000000;
    data_req   = 1'b0;
    data_wr    = 1'b0;
    data_wstrb = 4'h0;
    data_addr  = 32'h0;
    data_wdata = 32'h0;

    // 1: request held through reset, granted the cycle reset drops.
    drive(1'b1, 1'b1, 32'h1c000000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 32'h0);
    drive(1'b1, 1'b1, 32'h1c000000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 32'h0);
    drive(1'b0, 1'b1, 32'h1c000000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1, 32'h465a0000, 32'h0);
    idle();

    // 2: partial store then reload of the same word.
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h100, 32'hdeadbeef, 2, 32'h0, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h100, 32'h0, 2, 32'h0, 32'h5a5abeef);
    idle();

    // 3: sustained contention gives D,D,D,D,I.
    foreach (pat3[i]) both(1'b0, pat3[i]);
    idle();

    // 4: back-to-back fetches.
    drive(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1, 32'h5a5a0000, 32'h0);
    drive(1'b0, 1'b1, 32'h4, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1, 32'h5a5a0004, 32'h0);
    drive(1'b0, 1'b1, 32'h8, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1, 32'h5a5a0008, 32'h0);
    idle();

    // 5: counter saturated, reset right after a data grant cancels it and clears the counter.
    for (int i = 0; i < 4; i++) both(1'b0, 2);
    both(1'b1, 0);
    both(1'b0, 2);
    idle();
    idle();

    // 6: inst_req gap restarts the counter.
    both(1'b0, 2);
    both(1'b0, 2);
    idle();
    foreach (pat6[i]) both(1'b0, pat6[i]);
    idle();
    idle();
    idle();

    check("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
